// File: rtl/fifo_reader.sv
// Consumer-side reader for the synchronous FIFO: absorbs the one-cycle read
// latency in a 2-entry buffer and re-presents words on a valid/ready handshake.
module fifo_reader #(
    parameter int DATA_W = 14,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_rd_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    output logic [CNT_W-1:0]  word_cnt
);

    logic [DATA_W-1:0] head_q;
    logic [DATA_W-1:0] tail_q;
    logic [1:0]        cnt_q;
    logic              inflight_q;
    logic [CNT_W-1:0]  word_cnt_q;

    logic              pop;
    logic              capture;
    logic [2:0]        occ;

    // Reads are issued only while buffered plus in-flight words, minus the one
    // leaving this cycle, leave a free slot; this is what keeps cnt+inflight<=2.
    always_comb begin
        pop        = (cnt_q != 2'd0) && out_ready && !flush;
        capture    = inflight_q && !flush;
        occ        = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
        fifo_rd_en = !rst && !flush && !fifo_empty && (occ < 3'd2);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            cnt_q      <= 2'd0;
            inflight_q <= 1'b0;
            word_cnt_q <= '0;
        end else if (flush) begin
            cnt_q      <= 2'd0;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= fifo_rd_en;
            word_cnt_q <= word_cnt_q + CNT_W'(pop);
            // Simultaneous capture and pop shifts the buffer so order is kept.
            case ({capture, pop})
                2'b10: begin
                    if (cnt_q == 2'd0) head_q <= fifo_data;
                    else               tail_q <= fifo_data;
                    cnt_q <= cnt_q + 2'd1;
                end
                2'b01: begin
                    head_q <= tail_q;
                    cnt_q  <= cnt_q - 2'd1;
                end
                2'b11: begin
                    if (cnt_q == 2'd1) begin
                        head_q <= fifo_data;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= fifo_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign out_valid = (cnt_q != 2'd0);
    assign out_data  = head_q;
    assign word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_fifo_reader.sv
// Randomized bench for fifo_reader: a behavioural FIFO feeds the DUT and a
// queue-based reference of delivered words checks every cycle.
module tb_fifo_reader;

    localparam int DATA_W = 14;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_data = '0;
    logic              fifo_rd_en;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              flush;
    logic [CNT_W-1:0]  word_cnt;

    fifo_reader #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .flush      (flush),
        .word_cnt   (word_cnt)
    );

    always #5 clk = ~clk;

    // Source FIFO: stimulus appends at src_wr, reads advance src_rd with one-cycle latency.
    logic [DATA_W-1:0] src_mem [0:4095];
    int                src_wr = 0;
    int                src_rd = 0;

    assign fifo_empty = (src_rd == src_wr);

    always @(posedge clk) begin
        if (fifo_rd_en && (src_rd != src_wr)) begin
            fifo_data <= src_mem[src_rd];
            src_rd    <= src_rd + 1;
        end
    end

    int                err_count = 0;
    int                check_count = 0;

    logic [DATA_W-1:0] exp_q[$];
    bit                m_inflight = 1'b0;
    logic [DATA_W-1:0] m_word = '0;
    int                m_rd = 0;
    int                m_delivered = 0;

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        check_count++;
        if (act !== exp) begin
            err_count++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // One cycle: drive inputs after the falling edge, check, then advance the model.
    task automatic applyStimulus(input bit rdy, input bit fl, input int npush);
        bit exp_valid;
        bit exp_pop;
        bit exp_rd;
        @(negedge clk);
        for (int i = 0; i < npush; i++) begin
            src_mem[src_wr] = DATA_W'($urandom);
            src_wr++;
        end
        out_ready = rdy;
        flush     = fl;
        #1;
        exp_valid = (exp_q.size() != 0);
        exp_pop   = exp_valid && rdy && !fl;
        exp_rd    = !fl && (m_rd != src_wr) &&
                    ((exp_q.size() + int'(m_inflight) - int'(exp_pop)) < 2);
        checkOutput("out_valid", 32'(out_valid), 32'(exp_valid));
        if (exp_valid)
            checkOutput("out_data", 32'(out_data), 32'(exp_q[0]));
        checkOutput("fifo_rd_en", 32'(fifo_rd_en), 32'(exp_rd));
        checkOutput("word_cnt", 32'(word_cnt), 32'(m_delivered % (1 << CNT_W)));
        if (fl) begin
            exp_q.delete();
            m_inflight = 1'b0;
        end else begin
            if (exp_pop) begin
                void'(exp_q.pop_front());
                m_delivered++;
            end
            if (m_inflight)
                exp_q.push_back(m_word);
            m_inflight = exp_rd;
            if (exp_rd) begin
                m_word = src_mem[m_rd];
                m_rd++;
            end
        end
    endtask

    // Asynchronous reset in the middle of a cycle; outputs must clear at once.
    task automatic resetDut();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_data", 32'(out_data), 32'd0);
        checkOutput("rst_word_cnt", 32'(word_cnt), 32'd0);
        checkOutput("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        exp_q.delete();
        m_inflight  = 1'b0;
        m_delivered = 0;
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        out_ready = 1'b0;
        flush     = 1'b0;
        #1;
        checkOutput("init_valid", 32'(out_valid), 32'd0);
        checkOutput("init_rd_en", 32'(fifo_rd_en), 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;

        $display("[TB] streaming");
        applyStimulus(1'b1, 1'b0, 4);
        for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b0, 0);
        checkOutput("stream_cnt", 32'(word_cnt), 32'd4);

        $display("[TB] back-pressure");
        resetDut();
        applyStimulus(1'b0, 1'b0, 4);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 0);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 0);

        $display("[TB] empty boundary");
        resetDut();
        applyStimulus(1'b1, 1'b0, 1);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 0);

        $display("[TB] flush with in-flight word");
        resetDut();
        applyStimulus(1'b0, 1'b0, 1);
        applyStimulus(1'b0, 1'b0, 0);
        applyStimulus(1'b0, 1'b0, 1);
        applyStimulus(1'b0, 1'b1, 0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 0);
        checkOutput("flush_cnt", 32'(word_cnt), 32'd0);

        $display("[TB] counter wrap");
        resetDut();
        applyStimulus(1'b1, 1'b0, 17);
        for (int i = 0; i < 24; i++) applyStimulus(1'b1, 1'b0, 0);
        checkOutput("wrap_cnt", 32'(word_cnt), 32'd1);

        $display("[TB] random traffic");
        for (int i = 0; i < 600; i++) begin
            if (i == 300) resetDut();
            applyStimulus($urandom_range(0, 3) != 0,
                          $urandom_range(0, 19) == 0,
                          ((src_wr - m_rd) < 6) ? int'($urandom_range(0, 2)) : 0);
        end

        $display("Result: errors=%0d of %0d checks", err_count, check_count);
        $finish;
    end

endmodule

// File: doc/fifo_reader.md
# fifo_reader

Consumer-side controller for the team's synchronous FIFO: pops words with the FIFO's registered one-cycle read latency and re-presents them downstream on a valid/ready handshake. A 2-entry output buffer absorbs the read latency, so downstream back-pressure never loses a word and full throughput is sustained. It sits between the instruction/operand queue and the next pipeline stage.

## Interface
Parameters:
- DATA_W, 14, word width; must match the attached FIFO's DATA_W
- CNT_W, 16, width of the delivered-word counter

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- fifo_empty  in  1  empty flag from the FIFO
- fifo_data  in  DATA_W  FIFO data_out (registered, valid the cycle after an accepted read)
- fifo_rd_en  out  1  read request to the FIFO (combinational)
- out_valid  out  1  out_data holds a word
- out_ready  in  1  downstream accepts the word this cycle
- out_data  out  DATA_W  oldest buffered word
- flush  in  1  synchronous discard of buffered and in-flight words
- word_cnt  out  CNT_W  number of words delivered (out_valid && out_ready), wraps modulo 2^CNT_W

## Operation
- State: 2-entry buffer (head/tail slots), occupancy cnt (0..2), inflight_q flag (read issued last cycle), word_cnt.
- pop = out_valid && out_ready && !flush.
- fifo_rd_en = !rst && !flush && !fifo_empty && (cnt + inflight_q - pop) < 2; the out_ready -> fifo_rd_en combinational path is intentional and enables one word per cycle.
- fifo_rd_en is never asserted while fifo_empty=1. Every asserted read is therefore accepted by the FIFO, and inflight_q <= fifo_rd_en at each edge.
- Capture: when inflight_q=1 (and no flush), fifo_data is written into the buffer at the tail at the end of that cycle.
- Simultaneous capture and pop: the head leaves and the new word enters in order; cnt is unchanged.
- out_valid = (cnt != 0); out_data = head slot. Both are registered with no combinational path from fifo_data.
- Ordering: words leave in exactly the FIFO order; none is dropped or duplicated absent flush.
- flush: at the next edge cnt <= 0 and inflight_q <= 0, so a word arriving from a read issued the previous cycle is discarded. fifo_rd_en=0 and pop is suppressed during the flush cycle. The FIFO contents are not affected.
- Overflow is impossible by construction: cnt + inflight_q <= 2 always.
- word_cnt increments by 1 on each pop; 2^CNT_W-1 wraps to 0.
- Reset (asynchronous, any time, including mid-transfer): cnt=0, inflight_q=0, word_cnt=0, out_data=0, out_valid=0. fifo_rd_en is forced to 0 while rst=1. An in-flight word is discarded.

## Timing
- Read latency: fifo_rd_en high in cycle N; word in fifo_data during N+1; out_valid high in N+2.
- First-word latency from fifo_empty falling to out_valid: 2 cycles.
- Steady state with out_ready=1 and FIFO non-empty: one word per cycle, fifo_rd_en held high.
- out_ready=0: at most 2 further reads are issued, then fifo_rd_en drops. Once the buffer is full, out_data/out_valid stay stable until accepted.
- When out_ready returns to 1, output resumes in the same cycle with no bubble, provided cnt=2.

## Test plan
- Reset state: assert rst mid-stream -> out_valid=0, out_data=0, word_cnt=0, fifo_rd_en=0 immediately (asynchronous). After release, no stale word appears.
- Streaming: FIFO preloaded with 0x0001,0x0002,0x0003,0x0004 and out_ready=1 -> fifo_rd_en high for 4 consecutive cycles. out_data is 0x0001..0x0004 on consecutive cycles starting 2 cycles after the first read. word_cnt=4.
- Back-pressure: out_ready=0 with 4 words queued -> exactly 2 reads issued, out_data holds 0x0001. out_ready=1 for 4 cycles -> 0x0001..0x0004 in order, no gaps for the first 2.
- Empty boundary: FIFO holds 1 word -> single fifo_rd_en pulse, then fifo_rd_en=0 while fifo_empty=1. out_valid is high for exactly 1 cycle with out_ready=1.
- Flush with in-flight word: assert flush in the cycle after a read, while the buffer holds 1 word -> next cycle out_valid=0. The in-flight word never appears, and word_cnt is unchanged.
- Counter wrap: CNT_W=4, deliver 17 words -> word_cnt reads 1.
